mmio_gpio_pwm: RTL and testbench
================================

# mmio_gpio_pwm

Parametrised memory-mapped GPIO/PWM peripheral for the VexRiscv data bus IO window. It replaces hard-wired IO register decoding with a slave that has:
- N LEDs, N RGB channels with per-channel shadowed PWM duty and a runtime-programmable PWM period.
- Sticky button-edge capture with write-1-to-clear, plus a maskable interrupt.
- Synchronised switch inputs.

It sits behind the address decoder when address bit 31 (IO select) is set.

## Interface
- CLK_FREQ, 100000000, system clock in Hz
- PWM_FREQ, 20000, reset-default PWM frequency
- WL, 32, bus data width
- N_LEDS, 4, plain LED outputs (1..WL)
- N_RGB, 2, RGB channels (1..4)
- N_BTN, 4, debounced button inputs (1..WL)
- N_SW, 4, switch inputs (1..WL)
- PWM_WL, $clog2(CLK_FREQ/PWM_FREQ), period/duty counter width (13 at defaults)
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  bus command strobe; always accepted, no ready
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  6  byte address within IO window; bits [5:2] = register index
- cmd_wdata  in  WL  write data
- cmd_be  in  WL/8  byte enables for writes
- rsp_valid  out  1  read data valid
- rsp_data  out  WL  read data
- btn  in  N_BTN  debounced, already synchronous button levels
- sw  in  N_SW  asynchronous switch levels
- leds  out  N_LEDS  LED drive
- rgb  out  3*N_RGB  channel k on bits [3k+2:3k]
- irq  out  1  level interrupt, registered

## Operation
Register map (index, access, reset value):
- 0 SCRATCH, RW, 0
- 1 LEDS, RW, 0; bits [N_LEDS-1:0]
- 2 BTN_STATE, RO; current btn
- 3 BTN_EVENT, RW1C, 0; sticky rising-edge flags
- 4 IRQ_EN, RW, 0; per-button mask
- 5 SW_STATE, RO; sw after the 2-flop synchroniser
- 6 PWM_PERIOD, RW, CLK_FREQ/PWM_FREQ-1; [PWM_WL-1:0]
- 8+2k RGBk_COLOR, RW, 0; [2:0]
- 9+2k RGBk_DUTY, RW, 0; [PWM_WL-1:0]

Bus access rules:
- Unused indices and channels k ≥ N_RGB read 0; writes to them are ignored.
- Writes to RO registers are ignored.
- Unimplemented bits read 0.
- Byte lanes with cmd_be=0 are left unchanged, including W1C lanes.

Button edges and interrupt:
- Edge detect: BTN_EVENT[i] sets when btn[i] was 0 in the previous cycle and is 1 now.
- Simultaneous set and W1C clear on the same bit: set wins.
- irq is registered from |(BTN_EVENT & IRQ_EN).

PWM:
- A free counter runs 0..P, where P is the active period (period = P+1 cycles), then wraps to 0.
- Channel k output is on when counter < active duty_k.
- rgb[3k+2:3k] = COLOR_k & {3{on_k}}.
- duty=0 gives always off; duty > P gives always on; P=0 gives on = (duty≠0).
- Shadowing: written PERIOD/DUTY values are held in shadow registers and are copied to the active registers in the cycle the counter wraps (counter==P). The output therefore never glitches mid-period.
- Reading PERIOD or DUTY returns the shadow value.

## Timing
- Write: the register updates on the clk edge where cmd_valid & cmd_wr. leds reflects the write 1 cycle later.
- Read: rsp_valid and rsp_data are asserted exactly 1 cycle after cmd_valid & !cmd_wr, for 1 cycle.
  - Read data is sampled from register state before any same-cycle update.
  - A read of BTN_EVENT returns the flags before a clear in the same cycle.
  - Back-to-back reads give back-to-back responses.
- SW_STATE lags sw by 2 cycles.
- Edge → BTN_EVENT: 1 cycle. BTN_EVENT → irq: 1 further cycle.
- A duty/period write takes effect at the next wrap: between 1 and P+1 cycles after the write.
- Reset: asynchronous assert; all registers take the listed reset values.
  - Outputs: leds=0, rgb=0, irq=0, rsp_valid=0, rsp_data=0.
  - PWM counter=0; active period=default, active duty=0.
  - Reset mid-PWM-period aborts immediately.

## Structure
- Package mmio_gpio_pwm_pkg holds:
  - the register-index enum (SCRATCH_REG … RGB_DUTY_BASE);
  - REG_SPACE=16;
  - the default-period function.
- Sub-module pwm_channel: shadow duty, active duty, compare against the shared counter, colour masking. It is instantiated N_RGB times in a generate loop.
- The counter, period shadowing and wrap strobe live in the top and are fanned out to every channel.

## Test plan
- Reset, then read indices 0–15 → PWM_PERIOD=4999 at defaults; all others 0 except BTN_STATE/SW_STATE live values; rsp_valid exactly 1 cycle after each read.
- Write LEDS=0xFFFFFFFF with be=4'b0001 → leds=4'hF; read back 0x0000000F. Then write with be=0 → unchanged.
- Pulse btn[2] high for 3 cycles with IRQ_EN=0x4 → BTN_EVENT=0x4 after 1 cycle, irq=1 after 2 cycles. W1C 0x4 → irq=0. A clear coincident with a new edge → flag stays 1.
- PERIOD=9, RGB0_COLOR=3'b101, RGB0_DUTY=3 → rgb[2:0]=3'b101 for 3 of every 10 cycles. Change duty to 7 mid-period → the new ratio appears only after the wrap; no short or long pulse.
- Duty=0 → constant off; duty=10 with P=9 → constant on; P=0 with duty=1 → constant on.
- Assert resetn low mid-period with irq=1 → all outputs 0 asynchronously; PWM restarts from counter 0 after release.

Source files
------------

// File: rtl/mmio_gpio_pwm_pkg.sv
// Shared definitions for the memory-mapped GPIO/PWM peripheral:
// register indices, register-space size and the reset PWM period.
package mmio_gpio_pwm_pkg;

  typedef enum logic [3:0] {
    SCRATCH_REG    = 4'd0,
    LEDS_REG       = 4'd1,
    BTN_STATE_REG  = 4'd2,
    BTN_EVENT_REG  = 4'd3,
    IRQ_EN_REG     = 4'd4,
    SW_STATE_REG   = 4'd5,
    PWM_PERIOD_REG = 4'd6,
    RGB_COLOR_BASE = 4'd8,
    RGB_DUTY_BASE  = 4'd9
  } reg_idx_e;

  localparam int REG_SPACE = 16;

  function automatic int default_period(input int clk_freq, input int pwm_freq);
    return clk_freq / pwm_freq - 1;
  endfunction

endpackage

// File: rtl/mmio_gpio_pwm_channel.sv
// One RGB PWM channel: colour register, shadow/active duty and
// compare against the shared period counter.
module pwm_channel
  import mmio_gpio_pwm_pkg::*;
#(
  parameter int PWM_WL = 13
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wrap,
  input  logic [PWM_WL-1:0] cnt,
  input  logic              color_we,
  input  logic [2:0]        color_wdata,
  input  logic              duty_we,
  input  logic [PWM_WL-1:0] duty_wdata,
  output logic [2:0]        color,
  output logic [PWM_WL-1:0] duty_shadow,
  output logic [2:0]        rgb
);

  logic [PWM_WL-1:0] duty_active;

  // Duty only moves to the active copy on a wrap, so a period is never cut short.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      color       <= 3'd0;
      duty_shadow <= '0;
      duty_active <= '0;
    end else begin
      if (color_we) color <= color_wdata;
      if (duty_we) duty_shadow <= duty_wdata;
      if (wrap) duty_active <= duty_shadow;
    end
  end

  assign rgb = color & {3{cnt < duty_active}};

endmodule

// File: rtl/mmio_gpio_pwm.sv
// GPIO/PWM slave for the IO window: LEDs, sticky button events with
// maskable interrupt, synchronised switches and shadowed RGB PWM.
module mmio_gpio_pwm
  import mmio_gpio_pwm_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int PWM_FREQ = 20000,
  parameter int WL       = 32,
  parameter int N_LEDS   = 4,
  parameter int N_RGB    = 2,
  parameter int N_BTN    = 4,
  parameter int N_SW     = 4,
  parameter int PWM_WL   = $clog2(CLK_FREQ / PWM_FREQ)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cmd_valid,
  input  logic               cmd_wr,
  input  logic [5:0]         cmd_addr,
  input  logic [WL-1:0]      cmd_wdata,
  input  logic [WL/8-1:0]    cmd_be,
  output logic               rsp_valid,
  output logic [WL-1:0]      rsp_data,
  input  logic [N_BTN-1:0]   btn,
  input  logic [N_SW-1:0]    sw,
  output logic [N_LEDS-1:0]  leds,
  output logic [3*N_RGB-1:0] rgb,
  output logic               irq
);

  localparam int NB = WL / 8;
  localparam logic [PWM_WL-1:0] PERIOD_RST = PWM_WL'(default_period(CLK_FREQ, PWM_FREQ));

  function automatic logic [WL-1:0] lane_mask(input logic [NB-1:0] be);
    logic [WL-1:0] m;
    for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  logic [3:0]        idx;
  logic              wr_en, rd_en, wrap;
  logic [WL-1:0]     wmask, rd_data, scratch;
  logic [N_BTN-1:0]  btn_prev, btn_event, irq_en, event_clr, event_next;
  logic [N_SW-1:0]   sw_meta, sw_sync;
  logic [PWM_WL-1:0] period_sh, period_act, cnt;
  logic [2:0]        color_arr [4];
  logic [PWM_WL-1:0] duty_arr [4];
  logic [1:0]        unused_addr;

  assign idx         = cmd_addr[5:2];
  assign unused_addr = cmd_addr[1:0];
  assign wr_en       = cmd_valid & cmd_wr;
  assign rd_en       = cmd_valid & ~cmd_wr;
  assign wmask       = lane_mask(cmd_be);
  assign wrap        = (cnt == period_act);

  // Set beats clear: a new edge survives a coincident write-1-to-clear.
  always_comb begin
    event_clr = '0;
    if (wr_en && idx == BTN_EVENT_REG) begin
      event_clr = cmd_wdata[N_BTN-1:0] & wmask[N_BTN-1:0];
    end else begin
      event_clr = '0;
    end
    event_next = (btn_event & ~event_clr) | (btn & ~btn_prev);
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      SCRATCH_REG:    rd_data = scratch;
      LEDS_REG:       rd_data[N_LEDS-1:0] = leds;
      BTN_STATE_REG:  rd_data[N_BTN-1:0] = btn;
      BTN_EVENT_REG:  rd_data[N_BTN-1:0] = btn_event;
      IRQ_EN_REG:     rd_data[N_BTN-1:0] = irq_en;
      SW_STATE_REG:   rd_data[N_SW-1:0] = sw_sync;
      PWM_PERIOD_REG: rd_data[PWM_WL-1:0] = period_sh;
      default: begin
        if (idx[3] && idx[0]) begin
          rd_data[PWM_WL-1:0] = duty_arr[idx[2:1]];
        end else if (idx[3]) begin
          rd_data[2:0] = color_arr[idx[2:1]];
        end else begin
          rd_data = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scratch    <= '0;
      leds       <= '0;
      btn_prev   <= '0;
      btn_event  <= '0;
      irq_en     <= '0;
      sw_meta    <= '0;
      sw_sync    <= '0;
      period_sh  <= PERIOD_RST;
      period_act <= PERIOD_RST;
      cnt        <= '0;
      irq        <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      btn_prev  <= btn;
      btn_event <= event_next;
      sw_meta   <= sw;
      sw_sync   <= sw_meta;
      irq       <= |(btn_event & irq_en);
      rsp_valid <= rd_en;
      rsp_data  <= rd_en ? rd_data : '0;
      if (wr_en && idx == SCRATCH_REG)
        scratch <= (scratch & ~wmask) | (cmd_wdata & wmask);
      if (wr_en && idx == LEDS_REG)
        leds <= (leds & ~wmask[N_LEDS-1:0]) | (cmd_wdata[N_LEDS-1:0] & wmask[N_LEDS-1:0]);
      if (wr_en && idx == IRQ_EN_REG)
        irq_en <= (irq_en & ~wmask[N_BTN-1:0]) | (cmd_wdata[N_BTN-1:0] & wmask[N_BTN-1:0]);
      if (wr_en && idx == PWM_PERIOD_REG)
        period_sh <= (period_sh & ~wmask[PWM_WL-1:0]) | (cmd_wdata[PWM_WL-1:0] & wmask[PWM_WL-1:0]);
      if (wrap) begin
        cnt        <= '0;
        period_act <= period_sh;
      end else begin
        cnt <= cnt + PWM_WL'(1);
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_ch
    if (k < N_RGB) begin : g_on
      logic              color_we, duty_we;
      logic [2:0]        color_new;
      logic [PWM_WL-1:0] duty_new;

      assign color_we  = wr_en && (idx == 4'(int'(RGB_COLOR_BASE) + 2 * k));
      assign duty_we   = wr_en && (idx == 4'(int'(RGB_DUTY_BASE) + 2 * k));
      assign color_new = (color_arr[k] & ~wmask[2:0]) | (cmd_wdata[2:0] & wmask[2:0]);
      assign duty_new  = (duty_arr[k] & ~wmask[PWM_WL-1:0]) | (cmd_wdata[PWM_WL-1:0] & wmask[PWM_WL-1:0]);

      pwm_channel #(.PWM_WL(PWM_WL)) u_ch (
        .clk        (clk),
        .resetn     (resetn),
        .wrap       (wrap),
        .cnt        (cnt),
        .color_we   (color_we),
        .color_wdata(color_new),
        .duty_we    (duty_we),
        .duty_wdata (duty_new),
        .color      (color_arr[k]),
        .duty_shadow(duty_arr[k]),
        .rgb        (rgb[3*k +: 3])
      );
    end else begin : g_off
      assign color_arr[k] = 3'd0;
      assign duty_arr[k]  = '0;
    end
  end

endmodule

// File: tb/tb_mmio_gpio_pwm.sv
// Randomised bench for mmio_gpio_pwm: a register-level behavioural model
// is compared against the DUT after every clock, plus literal anchor checks.
module tb_mmio_gpio_pwm;

  localparam int N_RGB = 2;
  localparam int DEF_P = 4999;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [5:0]  cmd_addr = 6'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic [3:0]  cmd_be = 4'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [3:0]  btn = 4'd0, sw = 4'd0;
  logic [3:0]  leds;
  logic [5:0]  rgb;
  logic        irq;

  always #5 clk = ~clk;

  mmio_gpio_pwm dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .btn(btn), .sw(sw),
    .leds(leds), .rgb(rgb), .irq(irq)
  );

  int checks = 0, errors = 0;

  // Behavioural model of the register file and PWM
  logic [31:0] m_scratch;
  logic [3:0]  m_leds, m_ev, m_ien, m_btn_prev;
  logic        m_irq, exp_valid;
  logic [31:0] exp_data;
  int          m_period_sh, m_period_act, m_cnt;
  int          m_color [N_RGB];
  int          m_duty_sh [N_RGB];
  int          m_duty_act [N_RGB];
  logic [3:0]  sw_hist [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] read_model(input int idx);
    int k;
    case (idx)
      0: return m_scratch;
      1: return {28'd0, m_leds};
      2: return {28'd0, btn};
      3: return {28'd0, m_ev};
      4: return {28'd0, m_ien};
      5: return {28'd0, sw_hist[1]};
      6: return 32'(m_period_sh);
      default: begin
        if (idx >= 8) begin
          k = (idx - 8) / 2;
          if (k < N_RGB) return (idx % 2 == 1) ? 32'(m_duty_sh[k]) : 32'(m_color[k]);
        end
        return 32'd0;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_scratch = 32'd0; m_leds = 4'd0; m_ev = 4'd0; m_ien = 4'd0; m_btn_prev = 4'd0;
    m_irq = 1'b0; exp_valid = 1'b0; exp_data = 32'd0;
    m_period_sh = DEF_P; m_period_act = DEF_P; m_cnt = 0;
    for (int k = 0; k < N_RGB; k++) begin
      m_color[k] = 0; m_duty_sh[k] = 0; m_duty_act[k] = 0;
    end
    sw_hist = '{4'd0, 4'd0};
  endtask

  task automatic model_step();
    int idx, k;
    logic [31:0] t;
    logic [3:0] clr;
    logic nirq;
    idx = int'(cmd_addr[5:2]);
    exp_valid = cmd_valid && !cmd_wr;
    exp_data  = exp_valid ? read_model(idx) : 32'd0;
    nirq = |(m_ev & m_ien);
    clr = 4'd0;
    if (m_cnt == m_period_act) begin
      m_cnt = 0;
      m_period_act = m_period_sh;
      for (int c = 0; c < N_RGB; c++) m_duty_act[c] = m_duty_sh[c];
    end else begin
      m_cnt++;
    end
    if (cmd_valid && cmd_wr) begin
      case (idx)
        0: m_scratch = merge(m_scratch, cmd_wdata, cmd_be);
        1: begin t = merge({28'd0, m_leds}, cmd_wdata, cmd_be); m_leds = t[3:0]; end
        3: begin t = merge(32'd0, cmd_wdata, cmd_be); clr = t[3:0]; end
        4: begin t = merge({28'd0, m_ien}, cmd_wdata, cmd_be); m_ien = t[3:0]; end
        6: m_period_sh = int'(merge(32'(m_period_sh), cmd_wdata, cmd_be) & 32'h1FFF);
        default: begin
          if (idx >= 8) begin
            k = (idx - 8) / 2;
            if (k < N_RGB) begin
              if (idx % 2 == 1) m_duty_sh[k] = int'(merge(32'(m_duty_sh[k]), cmd_wdata, cmd_be) & 32'h1FFF);
              else m_color[k] = int'(merge(32'(m_color[k]), cmd_wdata, cmd_be) & 32'h7);
            end
          end
        end
      endcase
    end
    m_ev = (m_ev & ~clr) | (btn & ~m_btn_prev);
    m_btn_prev = btn;
    m_irq = nirq;
    sw_hist.push_front(sw);
    void'(sw_hist.pop_back());
  endtask

  function automatic logic [5:0] exp_rgb();
    logic [5:0] r;
    r = 6'd0;
    for (int k = 0; k < N_RGB; k++)
      if (m_cnt < m_duty_act[k]) r[3*k +: 3] = 3'(m_color[k]);
    return r;
  endfunction

  task automatic compare_all();
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
    if (exp_valid) check("rsp_data", rsp_data, exp_data);
    check("leds", {28'd0, leds}, {28'd0, m_leds});
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    check("rgb", {26'd0, rgb}, {26'd0, exp_rgb()});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!resetn) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic wr(input int idx, input logic [31:0] data, input logic [3:0] be);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 6'(idx * 4); cmd_wdata = data; cmd_be = be;
    tick();
    cmd_valid = 1'b0; cmd_wr = 1'b0;
  endtask

  task automatic rd(input int idx, output logic [31:0] d);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 6'(idx * 4);
    tick();
    cmd_valid = 1'b0;
    d = rsp_data;
  endtask

  task automatic count_on(output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rgb[2:0] != 3'd0) n++;
    end
  endtask

  initial begin
    logic [31:0] d;
    int n, idx;
    sw = 4'b1010;
    #2 resetn = 1'b0;
    #1;
    check("rst_leds", {28'd0, leds}, 32'd0);
    check("rst_rgb", {26'd0, rgb}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rsp", rsp_data, 32'd0);
    model_reset();
    tick(); tick();
    resetn = 1'b1;

    // Back-to-back reads of the whole register space
    for (int i = 0; i < 16; i++) begin
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 6'(i * 4);
      tick();
      if (i == 6) check("period_rst", rsp_data, 32'd4999);
      if (i == 5) check("sw_state", rsp_data, 32'h0000000A);
    end
    cmd_valid = 1'b0;
    tick();

    wr(1, 32'hFFFFFFFF, 4'b0001);
    check("leds_write", {28'd0, leds}, 32'h0000000F);
    rd(1, d);
    check("leds_read", d, 32'h0000000F);
    wr(1, 32'h00000000, 4'b0000);
    check("leds_be0", {28'd0, leds}, 32'h0000000F);

    // PWM: period 9, colour 101, duty 3
    wr(6, 32'd9, 4'hF);
    wr(8, 32'd5, 4'hF);
    wr(9, 32'd3, 4'hF);
    repeat (5010) tick();
    count_on(n);
    check("pwm_duty3", 32'(n), 32'd3);
    wr(9, 32'd7, 4'hF);
    repeat (25) tick();
    count_on(n);
    check("pwm_duty7", 32'(n), 32'd7);
    wr(9, 32'd0, 4'hF);
    repeat (25) tick();
    count_on(n);
    check("pwm_duty0", 32'(n), 32'd0);
    wr(9, 32'd10, 4'hF);
    repeat (25) tick();
    count_on(n);
    check("pwm_duty_gt_p", 32'(n), 32'd10);
    wr(6, 32'd0, 4'hF);
    wr(9, 32'd1, 4'hF);
    repeat (25) tick();
    count_on(n);
    check("pwm_p0", 32'(n), 32'd10);

    // Button edge, interrupt and write-1-to-clear
    wr(4, 32'd4, 4'hF);
    btn = 4'b0100;
    tick();
    check("irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check("irq_set", {31'd0, irq}, 32'd1);
    tick();
    btn = 4'b0000;
    rd(3, d);
    check("btn_event", d, 32'd4);
    wr(3, 32'd4, 4'hF);
    tick();
    check("irq_clr", {31'd0, irq}, 32'd0);
    btn = 4'b0100;
    tick();
    btn = 4'b0000;
    tick();
    btn = 4'b0100;
    wr(3, 32'd4, 4'hF);
    btn = 4'b0000;
    rd(3, d);
    check("set_wins", d, 32'd4);
    tick();
    check("irq_hold", {31'd0, irq}, 32'd1);

    // Asynchronous reset between clock edges
    #2 resetn = 1'b0;
    #1;
    check("arst_leds", {28'd0, leds}, 32'd0);
    check("arst_rgb", {26'd0, rgb}, 32'd0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    check("arst_valid", {31'd0, rsp_valid}, 32'd0);
    model_reset();
    tick(); tick();
    #3 resetn = 1'b1;
    rd(6, d);
    check("period_after_rst", d, 32'd4999);

    // Randomised traffic; PWM values kept small so periods stay short
    for (int i = 0; i < 6000; i++) begin
      idx = $urandom_range(0, 15);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_wr    = 1'($urandom_range(0, 1));
      cmd_addr  = {4'(idx), 2'($urandom)};
      cmd_be    = 4'($urandom);
      cmd_wdata = $urandom;
      if (idx == 6 || (idx >= 9 && idx % 2 == 1)) cmd_wdata = 32'($urandom_range(0, 24));
      if ($urandom_range(0, 5) == 0) btn = 4'($urandom);
      if ($urandom_range(0, 9) == 0) sw = 4'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
